// File: rtl/req_drain_encoder_pkg.sv
// ============================================================================
// Module  : req_enc_pkg
// Brief   : Shared defaults, FSM encoding and width helper for request encoders
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package req_enc_pkg;

    localparam int unsigned REQ_N_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Never returns 0, so a W-bit index port stays legal for tiny N.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/req_drain_encoder_msb_prio_enc.sv
// ============================================================================
// Module  : msb_prio_enc
// Brief   : Combinational MSB-first priority pick: index, one-hot and any flag
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module msb_prio_enc
    import req_enc_pkg::*;
#(
    parameter int unsigned N = REQ_N_DEFAULT,
    parameter int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         any
);

    // Ascending scan: the last set bit seen (highest index) overrides earlier picks.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx       = W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign any = |vec;

endmodule

`default_nettype wire

// File: rtl/req_drain_encoder.sv
// ============================================================================
// Module  : req_drain_encoder
// Brief   : Latches request pulses and drains them highest-index-first, one
//           binary index per valid/ready handshake
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_drain_encoder
    import req_enc_pkg::*;
#(
    parameter int unsigned N = REQ_N_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [idx_width(N)-1:0] out_idx,
    output logic [N-1:0]            out_onehot,
    output logic [N-1:0]            pending,
    output logic                    overflow
);

    localparam int unsigned W = idx_width(N);

    state_e         r_state;
    logic           r_valid;
    logic [W-1:0]   r_idx;
    logic [N-1:0]   r_onehot;
    logic [N-1:0]   r_pending;
    logic           r_overflow;

    logic [N-1:0]   w_eff;
    logic [W-1:0]   w_idx;
    logic [N-1:0]   w_onehot;
    logic           w_any;
    logic           w_load;

    // Same-cycle requests compete with pending ones, so a fresh pulse can win at once.
    assign w_eff  = r_pending | req_in;
    assign w_load = (r_state == IDLE) || (r_valid && out_ready);

    msb_prio_enc #(
        .N (N),
        .W (W)
    ) u_pick (
        .vec    (w_eff),
        .idx    (w_idx),
        .onehot (w_onehot),
        .any    (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_onehot   <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= |(req_in & r_pending);
            if (w_load) begin
                if (w_any) begin
                    r_state   <= HOLD;
                    r_valid   <= 1'b1;
                    r_idx     <= w_idx;
                    r_onehot  <= w_onehot;
                    r_pending <= w_eff & ~w_onehot;
                end else begin
                    // out_idx deliberately keeps the last issued value when draining empties.
                    r_state   <= IDLE;
                    r_valid   <= 1'b0;
                    r_onehot  <= '0;
                    r_pending <= '0;
                end
            end else begin
                r_pending <= w_eff;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;
    assign pending    = r_pending;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_req_drain_encoder.sv
// ============================================================================
// Module  : tb_req_drain_encoder
// Brief   : Directed plus randomized bench against a set-based reference model
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_req_drain_encoder;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_in;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic [N-1:0] pending;
    logic         overflow;

    int n_vec;
    int n_err;

    // Reference model: a set of waiting requests plus the one item on offer.
    bit [N-1:0] m_set;
    bit         m_offer;
    int         m_idx;
    bit         m_ovf;

    req_drain_encoder #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .pending    (pending),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int highest(input bit [N-1:0] s);
        int k;
        k = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (s[i] && k < 0) k = i;
        end
        return k;
    endfunction

    task automatic model_step(input bit [N-1:0] req, input bit rdy, input bit r);
        bit [N-1:0] pool;
        int         k;
        if (r) begin
            m_set   = '0;
            m_offer = 1'b0;
            m_idx   = 0;
            m_ovf   = 1'b0;
        end else begin
            m_ovf = (req & m_set) != 0;
            pool  = m_set | req;
            if (!m_offer || rdy) begin
                k = highest(pool);
                if (k >= 0) begin
                    m_offer = 1'b1;
                    m_idx   = k;
                    pool[k] = 1'b0;
                    m_set   = pool;
                end else begin
                    m_offer = 1'b0;
                    m_set   = '0;
                end
            end else begin
                m_set = pool;
            end
        end
    endtask

    task automatic cycle(input bit [N-1:0] req, input bit rdy, input bit r);
        bit [N-1:0] exp_oh;
        req_in    = req;
        out_ready = rdy;
        rst       = r;
        @(posedge clk);
        model_step(req, rdy, r);
        #1;
        exp_oh = '0;
        if (m_offer) exp_oh[m_idx] = 1'b1;
        check("out_valid",  32'(out_valid),  32'(m_offer));
        check("out_idx",    32'(out_idx),    32'(m_idx));
        check("out_onehot", 32'(out_onehot), 32'(exp_oh));
        check("pending",    32'(pending),    32'(m_set));
        check("overflow",   32'(overflow),   32'(m_ovf));
    endtask

    initial begin
        int exp_idx[4];
        int exp_pnd[4];
        exp_idx = '{7, 5, 2, 0};
        exp_pnd = '{8'h25, 8'h05, 8'h01, 8'h00};
        n_vec = 0;
        n_err = 0;
        m_set = '0; m_offer = 1'b0; m_idx = 0; m_ovf = 1'b0;
        req_in = '0; out_ready = 1'b0; rst = 1'b1;

        // Reset with requests asserted: all must be discarded.
        cycle(8'hFF, 1'b1, 1'b1);
        cycle(8'hFF, 1'b1, 1'b1);
        cycle(8'h00, 1'b1, 1'b0);
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_pending", 32'(pending),   32'h00);
        check("rst_idx",     32'(out_idx),   32'd0);
        check("rst_ovf",     32'(overflow),  32'd0);

        // Single request, one-cycle latency.
        cycle(8'h04, 1'b1, 1'b0);
        check("single_valid",  32'(out_valid),  32'd1);
        check("single_idx",    32'(out_idx),    32'd2);
        check("single_onehot", 32'(out_onehot), 32'h04);
        check("single_pend",   32'(pending),    32'h00);
        cycle(8'h00, 1'b1, 1'b0);
        check("single_done", 32'(out_valid), 32'd0);

        // Drain order, back-to-back.
        cycle(8'hA5, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_idx",   32'(out_idx),   32'(exp_idx[k]));
            check("drain_pend",  32'(pending),   32'(exp_pnd[k]));
            cycle(8'h00, 1'b1, 1'b0);
        end
        check("drain_end", 32'(out_valid), 32'd0);

        // Backpressure holds the offer stable.
        cycle(8'h81, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("bp_idx",  32'(out_idx), 32'd7);
            check("bp_pend", 32'(pending), 32'h01);
            cycle(8'h00, 1'b0, 1'b0);
        end
        check("bp_idx_last", 32'(out_idx), 32'd7);
        cycle(8'h00, 1'b1, 1'b0);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_idx",   32'(out_idx),   32'd0);
        cycle(8'h00, 1'b1, 1'b0);
        check("bp_idle", 32'(out_valid), 32'd0);

        // Duplicate request on a pending bit.
        cycle(8'h88, 1'b0, 1'b0);
        check("ovf_pre_pend", 32'(pending), 32'h08);
        cycle(8'h08, 1'b0, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_pend",  32'(pending),  32'h08);
        cycle(8'h00, 1'b0, 1'b0);
        check("ovf_clear", 32'(overflow), 32'd0);
        cycle(8'h00, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b0);

        // Reset after the first accept of a drain.
        cycle(8'hA5, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pend",  32'(pending),   32'h00);
        cycle(8'h00, 1'b1, 1'b0);
        check("mid_rst_quiet", 32'(out_valid), 32'd0);

        // Randomized traffic with occasional resets and backpressure.
        for (int t = 0; t < 400; t++) begin
            bit [N-1:0] rq;
            rq = N'($urandom) & N'($urandom) & N'($urandom);
            cycle(rq, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 63) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
